// File: rtl/dcache_miss_unit.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_unit
// Brief    : Data-cache memory-side controller with an MSHR table, a one-entry
//            write-through store buffer, line fill and halt drain.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_miss_unit #(
    parameter int N_MSHR   = 4,
    parameter int LSQ_ID_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                miss_valid,
    input  logic [63:0]         miss_addr,
    input  logic [LSQ_ID_W-1:0] miss_lsq_id,
    output logic                miss_ready,
    input  logic                st_valid,
    input  logic [63:0]         st_addr,
    input  logic [63:0]         st_data,
    output logic                st_ready,
    output logic [1:0]          proc2Dmem_command,
    output logic [63:0]         proc2Dmem_addr,
    output logic [63:0]         proc2Dmem_data,
    input  logic [3:0]          Dmem2proc_response,
    input  logic [63:0]         Dmem2proc_data,
    input  logic [3:0]          Dmem2proc_tag,
    output logic                fill_en,
    output logic [6:0]          fill_idx,
    output logic [21:0]         fill_tag,
    output logic [63:0]         fill_data,
    output logic                ld_done_valid,
    output logic [LSQ_ID_W-1:0] ld_done_lsq_id,
    output logic [63:0]         ld_done_data,
    input  logic                halt_req,
    output logic                halt_done
);
    localparam int         IDX_W     = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2
    } mshr_state_e;

    mshr_state_e         ent_state_q  [N_MSHR];
    mshr_state_e         ent_state_d  [N_MSHR];
    logic [60:0]         ent_addr_q   [N_MSHR];
    logic [60:0]         ent_addr_d   [N_MSHR];
    logic [LSQ_ID_W-1:0] ent_id_q     [N_MSHR];
    logic [LSQ_ID_W-1:0] ent_id_d     [N_MSHR];
    logic [3:0]          ent_tag_q    [N_MSHR];
    logic [3:0]          ent_tag_d    [N_MSHR];
    logic                ent_nofill_q [N_MSHR];
    logic                ent_nofill_d [N_MSHR];

    logic                sb_valid_q, sb_valid_d;
    logic [60:0]         sb_addr_q, sb_addr_d;
    logic [63:0]         sb_data_q, sb_data_d;
    logic                halt_q, halt_d;
    logic                alive_q, alive_d;

    logic                fill_en_q, fill_en_d;
    logic [6:0]          fill_idx_q, fill_idx_d;
    logic [21:0]         fill_tag_q, fill_tag_d;
    logic [63:0]         resp_data_q, resp_data_d;
    logic                ld_valid_q, ld_valid_d;
    logic [LSQ_ID_W-1:0] ld_id_q, ld_id_d;

    logic                any_free, all_free, any_pend, resp_hit;
    logic [IDX_W-1:0]    free_idx, pend_idx, resp_idx;
    logic                cmd_acc, st_acc, ld_acc, resp_store_hit;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^{miss_addr[2:0], st_addr[2:0]};

    // Lowest-index scans over registered state only.
    always_comb begin
        any_free = 1'b0;
        all_free = 1'b1;
        any_pend = 1'b0;
        resp_hit = 1'b0;
        free_idx = '0;
        pend_idx = '0;
        resp_idx = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (ent_state_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                all_free = 1'b0;
            end
            if (ent_state_q[i] == ST_PEND) begin
                any_pend = 1'b1;
                pend_idx = IDX_W'(i);
            end
            if (ent_state_q[i] == ST_WAIT && Dmem2proc_tag != 4'd0 && ent_tag_q[i] == Dmem2proc_tag) begin
                resp_hit = 1'b1;
                resp_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        proc2Dmem_command = CMD_NONE;
        proc2Dmem_addr    = 64'd0;
        proc2Dmem_data    = 64'd0;
        if (sb_valid_q) begin
            proc2Dmem_command = CMD_STORE;
            proc2Dmem_addr    = {sb_addr_q, 3'b000};
            proc2Dmem_data    = sb_data_q;
        end else if (any_pend) begin
            proc2Dmem_command = CMD_LOAD;
            proc2Dmem_addr    = {ent_addr_q[pend_idx], 3'b000};
        end
    end

    assign cmd_acc        = (Dmem2proc_response != 4'd0) && (proc2Dmem_command != CMD_NONE);
    assign st_acc         = cmd_acc && sb_valid_q;
    assign ld_acc         = cmd_acc && !sb_valid_q;
    assign resp_store_hit = st_acc && (ent_addr_q[resp_idx][28:0] == sb_addr_q[28:0]);

    assign miss_ready = alive_q && any_free && !halt_q;
    assign st_ready   = alive_q && !sb_valid_q && !halt_q;
    assign halt_done  = halt_q && all_free && !sb_valid_q;

    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            ent_state_d[i]  = ent_state_q[i];
            ent_addr_d[i]   = ent_addr_q[i];
            ent_id_d[i]     = ent_id_q[i];
            ent_tag_d[i]    = ent_tag_q[i];
            ent_nofill_d[i] = ent_nofill_q[i];
        end
        sb_valid_d  = sb_valid_q;
        sb_addr_d   = sb_addr_q;
        sb_data_d   = sb_data_q;
        halt_d      = halt_q | halt_req;
        alive_d     = 1'b1;
        fill_en_d   = 1'b0;
        fill_idx_d  = '0;
        fill_tag_d  = '0;
        resp_data_d = '0;
        ld_valid_d  = 1'b0;
        ld_id_d     = '0;

        if (st_valid && st_ready) begin
            sb_valid_d = 1'b1;
            sb_addr_d  = st_addr[63:3];
            sb_data_d  = st_data;
        end

        // A store reaching memory makes any in-flight fill of that line stale.
        if (st_acc) begin
            sb_valid_d = 1'b0;
            for (int i = 0; i < N_MSHR; i++) begin
                if (ent_state_q[i] != ST_FREE && ent_addr_q[i][28:0] == sb_addr_q[28:0]) begin
                    ent_nofill_d[i] = 1'b1;
                end
            end
        end

        if (ld_acc) begin
            ent_state_d[pend_idx] = ST_WAIT;
            ent_tag_d[pend_idx]   = Dmem2proc_response;
        end

        if (resp_hit) begin
            ent_state_d[resp_idx] = ST_FREE;
            fill_en_d   = !(ent_nofill_q[resp_idx] || resp_store_hit);
            fill_idx_d  = ent_addr_q[resp_idx][6:0];
            fill_tag_d  = ent_addr_q[resp_idx][28:7];
            resp_data_d = Dmem2proc_data;
            ld_valid_d  = 1'b1;
            ld_id_d     = ent_id_q[resp_idx];
        end

        if (miss_valid && miss_ready) begin
            ent_state_d[free_idx]  = ST_PEND;
            ent_addr_d[free_idx]   = miss_addr[63:3];
            ent_id_d[free_idx]     = miss_lsq_id;
            ent_nofill_d[free_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_MSHR; i++) begin
                ent_state_q[i]  <= ST_FREE;
                ent_addr_q[i]   <= '0;
                ent_id_q[i]     <= '0;
                ent_tag_q[i]    <= '0;
                ent_nofill_q[i] <= 1'b0;
            end
            sb_valid_q  <= 1'b0;
            sb_addr_q   <= '0;
            sb_data_q   <= '0;
            halt_q      <= 1'b0;
            alive_q     <= 1'b0;
            fill_en_q   <= 1'b0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            resp_data_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_id_q     <= '0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                ent_state_q[i]  <= ent_state_d[i];
                ent_addr_q[i]   <= ent_addr_d[i];
                ent_id_q[i]     <= ent_id_d[i];
                ent_tag_q[i]    <= ent_tag_d[i];
                ent_nofill_q[i] <= ent_nofill_d[i];
            end
            sb_valid_q  <= sb_valid_d;
            sb_addr_q   <= sb_addr_d;
            sb_data_q   <= sb_data_d;
            halt_q      <= halt_d;
            alive_q     <= alive_d;
            fill_en_q   <= fill_en_d;
            fill_idx_q  <= fill_idx_d;
            fill_tag_q  <= fill_tag_d;
            resp_data_q <= resp_data_d;
            ld_valid_q  <= ld_valid_d;
            ld_id_q     <= ld_id_d;
        end
    end

    assign fill_en        = fill_en_q;
    assign fill_idx       = fill_idx_q;
    assign fill_tag       = fill_tag_q;
    assign fill_data      = resp_data_q;
    assign ld_done_valid  = ld_valid_q;
    assign ld_done_lsq_id = ld_id_q;
    assign ld_done_data   = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_unit
// Brief    : Directed self-checking bench for dcache_miss_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic [63:0] miss_addr;
    logic [3:0]  miss_lsq_id;
    logic        miss_ready;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_ready;
    logic [1:0]  proc2Dmem_command;
    logic [63:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;
    logic        fill_en;
    logic [6:0]  fill_idx;
    logic [21:0] fill_tag;
    logic [63:0] fill_data;
    logic        ld_done_valid;
    logic [3:0]  ld_done_lsq_id;
    logic [63:0] ld_done_data;
    logic        halt_req;
    logic        halt_done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dcache_miss_unit #(.N_MSHR(4), .LSQ_ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_lsq_id(miss_lsq_id), .miss_ready(miss_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data), .Dmem2proc_tag(Dmem2proc_tag),
        .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
        .ld_done_valid(ld_done_valid), .ld_done_lsq_id(ld_done_lsq_id), .ld_done_data(ld_done_data),
        .halt_req(halt_req), .halt_done(halt_done)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_lsq_id = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        Dmem2proc_response = '0; Dmem2proc_data = '0; Dmem2proc_tag = '0; halt_req = 1'b0;
        cyc(); cyc(); #1;
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL reset_miss_ready got=%0h exp=0", miss_ready); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready got=%0h exp=0", st_ready); end
        checks++; if (proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL reset_cmd got=%0h exp=0", proc2Dmem_command); end
        checks++; if (fill_en !== 1'b0 || ld_done_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%0h/%0h exp=0/0", fill_en, ld_done_valid); end
        checks++; if (halt_done !== 1'b0) begin errors++; $display("FAIL reset_halt_done got=%0h exp=0", halt_done); end
        reset = 1'b0;
        cyc(); #1;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL post_reset_miss_ready got=%0h exp=1", miss_ready); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL post_reset_st_ready got=%0h exp=1", st_ready); end
    endtask

    task automatic test_single_miss();
        miss_valid = 1'b1; miss_addr = 64'h1238; miss_lsq_id = 4'h5; #1;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0h exp=1", miss_ready); end
        cyc();
        miss_valid = 1'b0; Dmem2proc_response = 4'd3; #1;
        checks++; if (proc2Dmem_command !== 2'd1) begin errors++; $display("FAIL single_cmd got=%0h exp=1", proc2Dmem_command); end
        checks++; if (proc2Dmem_addr !== 64'h1238) begin errors++; $display("FAIL single_addr got=%0h exp=1238", proc2Dmem_addr); end
        checks++; if (proc2Dmem_data !== 64'h0) begin errors++; $display("FAIL single_data got=%0h exp=0", proc2Dmem_data); end
        cyc();
        Dmem2proc_response = 4'd0; #1;
        checks++; if (proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL single_cmd_once got=%0h exp=0", proc2Dmem_command); end
        repeat (9) cyc();
        Dmem2proc_tag = 4'd3; Dmem2proc_data = 64'hAB;
        cyc();
        Dmem2proc_tag = 4'd0; Dmem2proc_data = 64'h0; #1;
        checks++; if (fill_en !== 1'b1) begin errors++; $display("FAIL single_fill_en got=%0h exp=1", fill_en); end
        checks++; if (fill_idx !== 7'h47) begin errors++; $display("FAIL single_fill_idx got=%0h exp=47", fill_idx); end
        checks++; if (fill_tag !== 22'h4) begin errors++; $display("FAIL single_fill_tag got=%0h exp=4", fill_tag); end
        checks++; if (fill_data !== 64'hAB) begin errors++; $display("FAIL single_fill_data got=%0h exp=ab", fill_data); end
        checks++; if (ld_done_valid !== 1'b1 || ld_done_lsq_id !== 4'h5) begin errors++; $display("FAIL single_ld_done got=%0h/%0h exp=1/5", ld_done_valid, ld_done_lsq_id); end
        checks++; if (ld_done_data !== 64'hAB) begin errors++; $display("FAIL single_ld_data got=%0h exp=ab", ld_done_data); end
        cyc(); #1;
        checks++; if (fill_en !== 1'b0 || ld_done_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end got=%0h/%0h exp=0/0", fill_en, ld_done_valid); end
    endtask

    task automatic test_retry();
        miss_valid = 1'b1; miss_addr = 64'h2000; miss_lsq_id = 4'h1;
        cyc();
        miss_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            Dmem2proc_response = (k == 3) ? 4'd7 : 4'd0; #1;
            checks++; if (proc2Dmem_command !== 2'd1 || proc2Dmem_addr !== 64'h2000) begin errors++; $display("FAIL retry_hold[%0d] got=%0h/%0h exp=1/2000", k, proc2Dmem_command, proc2Dmem_addr); end
            cyc();
        end
        Dmem2proc_response = 4'd0; #1;
        checks++; if (proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL retry_after got=%0h exp=0", proc2Dmem_command); end
        Dmem2proc_tag = 4'd7; Dmem2proc_data = 64'h77;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_lsq_id !== 4'h1) begin errors++; $display("FAIL retry_done got=%0h/%0h exp=1/1", ld_done_valid, ld_done_lsq_id); end
        cyc();
    endtask

    task automatic test_out_of_order();
        int order [4] = '{4, 2, 1, 3};
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_addr = 64'h1000 + 64'(i * 64); miss_lsq_id = 4'(8 + i); #1;
            checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL ooo_alloc_ready[%0d] got=%0h exp=1", i, miss_ready); end
            cyc();
        end
        miss_valid = 1'b0; #1;
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL ooo_full_ready got=%0h exp=0", miss_ready); end
        for (int i = 0; i < 4; i++) begin
            Dmem2proc_response = 4'(i + 1); #1;
            checks++; if (proc2Dmem_command !== 2'd1 || proc2Dmem_addr !== 64'h1000 + 64'(i * 64)) begin errors++; $display("FAIL ooo_issue[%0d] got=%0h/%0h exp=1/%0h", i, proc2Dmem_command, proc2Dmem_addr, 64'h1000 + 64'(i * 64)); end
            cyc();
        end
        Dmem2proc_response = 4'd0;
        for (int j = 0; j < 4; j++) begin
            Dmem2proc_tag = 4'(order[j]); Dmem2proc_data = 64'(order[j] * 16);
            if (j == 0) begin
                #1;
                checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL ooo_ready_before got=%0h exp=0", miss_ready); end
            end
            cyc();
            Dmem2proc_tag = 4'd0; #1;
            checks++; if (ld_done_valid !== 1'b1 || ld_done_lsq_id !== 4'(7 + order[j])) begin errors++; $display("FAIL ooo_done[tag %0d] got=%0h/%0h exp=1/%0h", order[j], ld_done_valid, ld_done_lsq_id, 7 + order[j]); end
            checks++; if (ld_done_data !== 64'(order[j] * 16)) begin errors++; $display("FAIL ooo_data[tag %0d] got=%0h exp=%0h", order[j], ld_done_data, order[j] * 16); end
            if (j == 0) begin
                checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL ooo_ready_after got=%0h exp=1", miss_ready); end
            end
        end
        cyc();
    endtask

    task automatic test_store_priority();
        miss_valid = 1'b1; miss_addr = 64'h3000; miss_lsq_id = 4'h2;
        st_valid = 1'b1; st_addr = 64'h5000; st_data = 64'h1111; #1;
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL prio_st_ready got=%0h exp=1", st_ready); end
        cyc();
        miss_valid = 1'b0; st_valid = 1'b0; Dmem2proc_response = 4'd1; #1;
        checks++; if (proc2Dmem_command !== 2'd2 || proc2Dmem_addr !== 64'h5000 || proc2Dmem_data !== 64'h1111) begin errors++; $display("FAIL prio_store got=%0h/%0h/%0h exp=2/5000/1111", proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data); end
        cyc();
        Dmem2proc_response = 4'd2; #1;
        checks++; if (proc2Dmem_command !== 2'd1 || proc2Dmem_addr !== 64'h3000 || proc2Dmem_data !== 64'h0) begin errors++; $display("FAIL prio_load got=%0h/%0h/%0h exp=1/3000/0", proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL prio_sb_empty got=%0h exp=1", st_ready); end
        cyc();
        Dmem2proc_response = 4'd0; Dmem2proc_tag = 4'd2; Dmem2proc_data = 64'h22;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_lsq_id !== 4'h2 || fill_en !== 1'b1) begin errors++; $display("FAIL prio_done got=%0h/%0h/%0h exp=1/2/1", ld_done_valid, ld_done_lsq_id, fill_en); end
        cyc();
    endtask

    task automatic test_store_race();
        miss_valid = 1'b1; miss_addr = 64'h1238; miss_lsq_id = 4'h6;
        cyc();
        miss_valid = 1'b0; Dmem2proc_response = 4'd5;
        cyc();
        Dmem2proc_response = 4'd0; st_valid = 1'b1; st_addr = 64'h1238; st_data = 64'hFF;
        cyc();
        st_valid = 1'b0; Dmem2proc_response = 4'd1; #1;
        checks++; if (proc2Dmem_command !== 2'd2 || proc2Dmem_addr !== 64'h1238) begin errors++; $display("FAIL race_store got=%0h/%0h exp=2/1238", proc2Dmem_command, proc2Dmem_addr); end
        cyc();
        Dmem2proc_response = 4'd0; Dmem2proc_tag = 4'd5; Dmem2proc_data = 64'hCD;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_valid !== 1'b1 || ld_done_data !== 64'hCD) begin errors++; $display("FAIL race_done got=%0h/%0h exp=1/cd", ld_done_valid, ld_done_data); end
        checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL race_no_fill got=%0h exp=0", fill_en); end
        cyc();
    endtask

    task automatic test_halt();
        miss_valid = 1'b1; miss_addr = 64'h4000; miss_lsq_id = 4'h3;
        cyc();
        miss_addr = 64'h4040; miss_lsq_id = 4'h4; Dmem2proc_response = 4'd6;
        cyc();
        miss_valid = 1'b0; Dmem2proc_response = 4'd7; st_valid = 1'b1; st_addr = 64'h6000; st_data = 64'h66;
        cyc();
        st_valid = 1'b0; Dmem2proc_response = 4'd0; halt_req = 1'b1;
        cyc();
        halt_req = 1'b0; #1;
        checks++; if (miss_ready !== 1'b0 || st_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got=%0h/%0h exp=0/0", miss_ready, st_ready); end
        checks++; if (halt_done !== 1'b0 || proc2Dmem_command !== 2'd2) begin errors++; $display("FAIL halt_pending got=%0h/%0h exp=0/2", halt_done, proc2Dmem_command); end
        Dmem2proc_tag = 4'd6;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_lsq_id !== 4'h3 || halt_done !== 1'b0) begin errors++; $display("FAIL halt_resp1 got=%0h/%0h exp=3/0", ld_done_lsq_id, halt_done); end
        Dmem2proc_tag = 4'd7;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_lsq_id !== 4'h4 || halt_done !== 1'b0) begin errors++; $display("FAIL halt_resp2 got=%0h/%0h exp=4/0", ld_done_lsq_id, halt_done); end
        Dmem2proc_response = 4'd1;
        cyc();
        Dmem2proc_response = 4'd0; #1;
        checks++; if (halt_done !== 1'b1 || proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL halt_done got=%0h/%0h exp=1/0", halt_done, proc2Dmem_command); end
        cyc(); #1;
        checks++; if (halt_done !== 1'b1) begin errors++; $display("FAIL halt_hold got=%0h exp=1", halt_done); end
        reset = 1'b1;
        cyc(); #1;
        checks++; if (halt_done !== 1'b0 || miss_ready !== 1'b0 || st_ready !== 1'b0 || proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL halt_reset got=%0h/%0h/%0h/%0h exp=0/0/0/0", halt_done, miss_ready, st_ready, proc2Dmem_command); end
        reset = 1'b0;
        cyc(); #1;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL halt_reset_ready got=%0h exp=1", miss_ready); end
    endtask

    task automatic test_reset_drop();
        miss_valid = 1'b1; miss_addr = 64'h7000; miss_lsq_id = 4'h9;
        cyc();
        miss_valid = 1'b0; Dmem2proc_response = 4'd9;
        cyc();
        Dmem2proc_response = 4'd0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        Dmem2proc_tag = 4'd9; Dmem2proc_data = 64'h99;
        cyc();
        Dmem2proc_tag = 4'd0; #1;
        checks++; if (ld_done_valid !== 1'b0 || fill_en !== 1'b0) begin errors++; $display("FAIL drop_ignored got=%0h/%0h exp=0/0", ld_done_valid, fill_en); end
        checks++; if (proc2Dmem_command !== 2'd0) begin errors++; $display("FAIL drop_cmd got=%0h exp=0", proc2Dmem_command); end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_retry();
        test_out_of_order();
        test_store_priority();
        test_store_race();
        test_halt();
        test_reset_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
